// File: rtl/fifo_btn_ctrl.sv
// Input stage for the 8x4 FIFO. It debounces the enq/deq buttons and synchronizes the data switches.
// It issues guarded single-cycle strobes and reports presses that the FIFO cannot accept.

module fifo_btn_db #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_s2,
  output logic press
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Debounce state and stability counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a level change is accepted only after DB_CYCLES stable samples
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press   = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s2) begin
          state_d = ARMED;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      ARMED: begin
        if (!btn_s2) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = HELD;
          cnt_d   = CNT_ZERO;
          press   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!btn_s2) begin
          state_d = RELEASE;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      RELEASE: begin
        if (btn_s2) begin
          state_d = HELD;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

endmodule

module fifo_btn_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_enq,
  input  logic       btn_deq,
  input  logic [3:0] sw_in,
  input  logic       full,
  input  logic       empty,
  output logic       enq,
  output logic       deq,
  output logic [3:0] din,
  output logic       rej_full,
  output logic       rej_empty
);

  // Synchronizer bits are packed as {sw_in, btn_deq, btn_enq}
  logic [5:0] sync_s1_q, sync_s1_d;
  logic [5:0] sync_s2_q, sync_s2_d;
  logic       enq_press, deq_press;
  logic       enq_q, enq_d, deq_q, deq_d;
  logic       rej_full_q, rej_full_d, rej_empty_q, rej_empty_d;
  logic       deq_pend_q, deq_pend_d;
  logic [3:0] din_q, din_d;

  fifo_btn_db #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_enq (
    .clk    (clk),
    .rst    (rst),
    .btn_s2 (sync_s2_q[0]),
    .press  (enq_press)
  );

  fifo_btn_db #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_deq (
    .clk    (clk),
    .rst    (rst),
    .btn_s2 (sync_s2_q[1]),
    .press  (deq_press)
  );

  // Output, pending-dequeue and synchronizer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_s1_q   <= 6'd0;
      sync_s2_q   <= 6'd0;
      enq_q       <= 1'b0;
      deq_q       <= 1'b0;
      rej_full_q  <= 1'b0;
      rej_empty_q <= 1'b0;
      deq_pend_q  <= 1'b0;
      din_q       <= 4'd0;
    end else begin
      sync_s1_q   <= sync_s1_d;
      sync_s2_q   <= sync_s2_d;
      enq_q       <= enq_d;
      deq_q       <= deq_d;
      rej_full_q  <= rej_full_d;
      rej_empty_q <= rej_empty_d;
      deq_pend_q  <= deq_pend_d;
      din_q       <= din_d;
    end
  end

  // Strobe arbitration: an enq press wins the cycle and any dequeue waits one cycle
  always_comb begin
    sync_s1_d   = {sw_in, btn_deq, btn_enq};
    sync_s2_d   = sync_s1_q;
    enq_d       = 1'b0;
    deq_d       = 1'b0;
    rej_full_d  = 1'b0;
    rej_empty_d = 1'b0;
    deq_pend_d  = 1'b0;
    din_d       = din_q;
    if (enq_press) begin
      if (!full) begin
        enq_d = 1'b1;
        din_d = sync_s2_q[5:2];
      end else begin
        rej_full_d = 1'b1;
      end
    end else begin
      enq_d = 1'b0;
    end
    if (deq_press || deq_pend_q) begin
      if (enq_press) begin
        deq_pend_d = 1'b1;
      end else if (!empty) begin
        deq_d = 1'b1;
      end else begin
        rej_empty_d = 1'b1;
      end
    end else begin
      deq_pend_d = 1'b0;
    end
  end

  assign enq       = enq_q;
  assign deq       = deq_q;
  assign din       = din_q;
  assign rej_full  = rej_full_q;
  assign rej_empty = rej_empty_q;

endmodule

// File: tb/tb_fifo_btn_ctrl.sv
// Directed bench for fifo_btn_ctrl: expected pulses are queued with their due cycle
// and compared on the falling edge by a monitor.

module tb_fifo_btn_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_enq, btn_deq;
  logic [3:0] sw_in;
  logic       full, empty;
  logic       enq, deq, rej_full, rej_empty;
  logic [3:0] din;

  typedef struct {
    int         cyc;
    logic [3:0] pulses;  // {enq, deq, rej_full, rej_empty}
    logic [3:0] din;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  logic [3:0] mon_pulses;
  logic [3:0] exp_din = 4'h0;
  int         cyc = 0;
  int         checks = 0;
  int         passes = 0;

  fifo_btn_ctrl #(.DB_CYCLES(4), .CNT_W(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_enq   (btn_enq),
    .btn_deq   (btn_deq),
    .sw_in     (sw_in),
    .full      (full),
    .empty     (empty),
    .enq       (enq),
    .deq       (deq),
    .din       (din),
    .rej_full  (rej_full),
    .rej_empty (rej_empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [3:0] p, input logic [3:0] d);
    exp_t e;
    e.cyc    = c;
    e.pulses = p;
    e.din    = d;
    q.push_back(e);
  endtask

  // Monitor: every cycle the outputs must match the queued expectation or be idle
  always @(negedge clk) begin
    if (rst) begin
      exp_din = 4'h0;
      check("rst_outs", {24'd0, enq, deq, rej_full, rej_empty, din}, 32'h0);
    end else begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        mon_e = q.pop_front();
        check("pulse_missed_at_cyc", cyc, mon_e.cyc);
      end
      mon_pulses = 4'b0000;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        mon_e      = q.pop_front();
        mon_pulses = mon_e.pulses;
        if (mon_e.pulses[3]) exp_din = mon_e.din;
      end
      check("pulses", {28'd0, enq, deq, rej_full, rej_empty}, {28'd0, mon_pulses});
      check("din", {28'd0, din}, {28'd0, exp_din});
    end
  end

  initial begin
    rst = 1'b1; btn_enq = 1'b0; btn_deq = 1'b0; sw_in = 4'h0; full = 1'b0; empty = 1'b0;
    #2;
    check("reset_outs", {24'd0, enq, deq, rej_full, rej_empty, din}, 32'h0);
    #8 rst = 1'b0;
    tick(1);

    // 1: clean enqueue press
    sw_in = 4'h2; btn_enq = 1'b1;
    push(cyc + 6, 4'b1000, 4'h2);
    tick(10); btn_enq = 1'b0; tick(10);
    check("t1_drained", q.size(), 0);

    // 2: bounce before a stable hold
    sw_in = 4'h5;
    btn_enq = 1'b1; tick(1); btn_enq = 1'b0; tick(1);
    btn_enq = 1'b1; tick(1); btn_enq = 1'b0; tick(1);
    btn_enq = 1'b1;
    push(cyc + 6, 4'b1000, 4'h5);
    tick(10); btn_enq = 1'b0; tick(10);
    check("t2_drained", q.size(), 0);

    // 3: guarding against full and empty, then a normal dequeue
    full = 1'b1; sw_in = 4'hA; btn_enq = 1'b1;
    push(cyc + 6, 4'b0010, 4'h0);
    tick(10); btn_enq = 1'b0; tick(10); full = 1'b0;
    empty = 1'b1; btn_deq = 1'b1;
    push(cyc + 6, 4'b0001, 4'h0);
    tick(10); btn_deq = 1'b0; tick(10); empty = 1'b0;
    btn_deq = 1'b1;
    push(cyc + 6, 4'b0100, 4'h0);
    tick(10); btn_deq = 1'b0; tick(10);
    check("t3_drained", q.size(), 0);

    // 4: simultaneous presses, enq first then deq one cycle later
    sw_in = 4'h9; btn_enq = 1'b1; btn_deq = 1'b1;
    push(cyc + 6, 4'b1000, 4'h9);
    push(cyc + 7, 4'b0100, 4'h0);
    tick(10); btn_enq = 1'b0; btn_deq = 1'b0; tick(10);
    check("t4_drained", q.size(), 0);

    // 5: reset while ARMED with the button still held
    sw_in = 4'h3; btn_enq = 1'b1;
    tick(3);
    rst = 1'b1;
    #1;
    check("t5_async_rst", {24'd0, enq, deq, rej_full, rej_empty, din}, 32'h0);
    tick(2);
    rst = 1'b0;
    push(cyc + 6, 4'b1000, 4'h3);
    tick(10); btn_enq = 1'b0; tick(10);
    check("t5_drained", q.size(), 0);

    // 6: long hold, chatter on release, then a second press
    sw_in = 4'h6; btn_enq = 1'b1;
    push(cyc + 6, 4'b1000, 4'h6);
    tick(50);
    btn_enq = 1'b0; tick(1); btn_enq = 1'b1; tick(1);
    btn_enq = 1'b0; tick(1); btn_enq = 1'b1; tick(1);
    btn_enq = 1'b0; tick(10);
    sw_in = 4'h7; btn_enq = 1'b1;
    push(cyc + 6, 4'b1000, 4'h7);
    tick(10); btn_enq = 1'b0; tick(10);
    check("t6_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
